// File: rtl/sync_fifo_stat_if.sv
// Handshake and status bundle for sync_fifo_stat.
// master: the FIFO user (writer/reader); slave: the FIFO itself.
interface sync_fifo_stat_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  logic                     flush;
  logic                     winc;
  logic [WIDTH-1:0]         wdata;
  logic                     rinc;
  logic [WIDTH-1:0]         rdata;
  logic                     full;
  logic                     empty;
  logic                     almost_full;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     clr_err;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output flush, winc, wdata, rinc, clr_err,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, winc, wdata, rinc, clr_err,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_stat.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// optional first-word-fall-through read, synchronous flush and sticky
// overflow/underflow flags. Status flags are decoded from the registered
// count so they move on the same edge as count.
module sync_fifo_stat #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter bit FWFT          = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  sync_fifo_stat_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_THRESH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count_q;
  logic              overflow_q;
  logic              underflow_q;

  logic full_c;
  logic empty_c;
  logic rd_ok;
  logic wr_ok;
  logic ovf_set;
  logic unf_set;

  // Accept/reject decode; flush swallows both requests without raising errors.
  // A write into a full FIFO is still accepted when a read frees the slot.
  always_comb begin
    full_c  = (count_q == DEPTH_C);
    empty_c = (count_q == '0);
    rd_ok   = bus.rinc & ~empty_c & ~bus.flush;
    wr_ok   = bus.winc & (~full_c | rd_ok) & ~bus.flush;
    ovf_set = bus.winc & full_c & ~rd_ok & ~bus.flush;
    unf_set = bus.rinc & empty_c & ~bus.flush;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wptr    <= '0;
      rptr    <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      if (wr_ok && !rd_ok) begin
        count_q <= count_q + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins over clr_err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_set | (overflow_q  & ~bus.clr_err);
      underflow_q <= unf_set | (underflow_q & ~bus.clr_err);
    end
  end

  // Storage write; contents survive reset and flush, only the pointers move.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem[wptr] <= bus.wdata;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      // Head word is presented directly; it is meaningful only while not empty.
      assign bus.rdata = mem[rptr];
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;

      // Registered read: the old head is captured even if the same slot is
      // being overwritten on this edge (full with simultaneous read+write).
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rdata_q <= '0;
        end else if (rd_ok) begin
          rdata_q <= mem[rptr];
        end
      end

      assign bus.rdata = rdata_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (count_q >= AFULL_C);
  assign bus.almost_empty = (count_q <= AEMPTY_C);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: doc/sync_fifo_stat.md
# sync_fifo_stat

Single-clock, parametrised FIFO for the UART datapath, used as the TX holding buffer and RX receive buffer where both sides share one clock, so no pointer synchronisers are needed. It generalises the dual-clock FIFO with several additions: an occupancy count, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, a synchronous flush, and sticky overflow/underflow error flags.

## Interface
- WIDTH, 8, data width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥4; ADDR_W = log2(DEPTH)
- AFULL_THRESH, DEPTH-2, almost_full asserted when count ≥ this (1..DEPTH)
- AEMPTY_THRESH, 2, almost_empty asserted when count ≤ this (0..DEPTH-1)
- FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  synchronous clear of FIFO contents
- winc  in  1  write request
- wdata  in  WIDTH  write data
- rinc  in  1  read request / pop
- rdata  out  WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_THRESH
- almost_empty  out  1  count ≤ AEMPTY_THRESH
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- clr_err  in  1  clears sticky error flags
- overflow  out  1  sticky: write attempted and rejected
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH×WIDTH array. Pointers wptr and rptr are ADDR_W bits wide and wrap modulo DEPTH. count is a separate register, ADDR_W+1 bits wide.
- Write accept: wr_ok = winc & (~full | rd_ok). This means a write is accepted when the FIFO is full, provided a read is accepted in the same cycle.
- Read accept: rd_ok = rinc & ~empty.
- On wr_ok:
  - mem[wptr] ← wdata.
  - wptr ← wptr+1.
- On rd_ok: rptr ← rptr+1.
- count update:
  - +1 on wr_ok only.
  - −1 on rd_ok only.
  - Unchanged when both or neither occur.
- full, empty, almost_full and almost_empty are decoded from the registered count, so they change in the same cycle as count.
- Read data, standard mode (FWFT=0):
  - On rd_ok, rdata ← mem[rptr], registered.
  - Otherwise rdata holds its value.
- Read data, FWFT mode (FWFT=1):
  - rdata = mem[rptr] combinationally whenever ~empty.
  - rinc pops that word.
  - While empty, rdata is don't-care; the bench checks it only when ~empty.
- Errors:
  - overflow ← 1 when winc & full & ~rd_ok.
  - underflow ← 1 when rinc & empty.
  - Rejected operations leave the pointers, count and memory unchanged.
  - clr_err clears both flags. If a new error occurs in the same cycle as clr_err, the flag sets, because set has priority over clear.
- flush:
  - Sets wptr, rptr and count to 0. Memory is not cleared.
  - Takes priority over winc/rinc in the same cycle; those requests are ignored and raise no error.
  - Does not clear overflow/underflow.
  - Does not change the registered rdata.
- Priority: rst_n > flush > normal operation.

## Timing
- Reset values: wptr=0, rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rdata=0 (standard mode).
- Write to flag update: one edge. After a write to an empty FIFO, empty deasserts in the next cycle.
- Read latency, standard mode: rdata is valid in the cycle after the rd_ok edge.
- Read latency, FWFT mode: the first word is visible on rdata in the cycle after the write edge that fills the empty FIFO. That is the same cycle in which empty=0.
- Full boundary with simultaneous read+write:
  - Both are accepted and count stays at DEPTH.
  - The read returns the old head before the overwrite of that slot.
- Empty boundary with simultaneous read+write:
  - The write is accepted, the read is rejected, and underflow sets.
  - count becomes 1.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap, and data order is preserved.
- Reset mid-operation: all state reaches the reset values at the next edge, regardless of winc/rinc/flush.

## Test plan
- Default params, reset, then write 0x01..0x10 (16 words) → full=1 and count=16 after the 16th edge. A 17th write sets overflow=1 and count stays 16.
- Read all 16 words in standard mode → rdata is 0x01..0x10, each one cycle after its rinc, and empty=1 after the last read. One further rinc → underflow=1; clr_err → 0.
- AFULL_THRESH=14, AEMPTY_THRESH=2, ramp count 0→16→0 → almost_empty=1 for count ≤2 and almost_full=1 for count ≥14, transitioning on the exact edges where count crosses the thresholds.
- While full, winc+rinc held for 20 cycles with an incrementing pattern → count stays 16, no overflow, and the read sequence is unbroken across pointer wrap.
- FWFT=1: write 0xA5 into an empty FIFO → next cycle empty=0 and rdata=0xA5 with no rinc. rinc → empty=1 the following cycle.
- Write 5 words, then assert flush together with winc → count=0 and empty=1 next cycle, the write is ignored, and the sticky flags are unchanged. Assert rst_n=0 mid-burst → all outputs take their reset values at the next edge.
